hwmod_multi: RTL and testbench

- Parametrised successor to the single-purpose hardware-monitor top.
- Monitors NUM_REGIONS independently configured protected data regions. Each region is owned by one code region.
- On any access-policy violation, asserts a sticky, registered reset to the MSP430 core. The reset is held for a minimum count and then released only once the CPU reaches RESET_HANDLER.
- Logs the offending region index, the violation cause and a saturating violation count for post-reset diagnosis. Sits beside the core, fed by the same pc/data/dma/irq taps.

---
 rtl/hwmod_multi.sv | 181 ++++++++++++++++++
 tb/tb_hwmod_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hwmod_multi.sv
// hwmod_multi: multi-region hardware access monitor for an MSP430 core.
//
// Watches NUM_REGIONS protected data regions. Each region has an owning code
// range. When an access-policy violation is seen, a sticky registered reset
// is raised towards the core. It stays high for at least RESET_HOLD cycles
// and is released once the CPU fetches from RESET_HANDLER. The region index,
// cause and a saturating count of violations are kept for post-reset
// diagnosis. These clear only on puc, not on the monitor's own reset pulse.
//
// Optional feature: define HWMOD_MULTI_DMA_CHECK_EN to flag DMA accesses
// into any enabled region (cause 3'b100). When it is undefined, dma_en and
// dma_addr are accepted but ignored.
//
// Ports:
//   clk, puc          clock, synchronous active-high reset
//   pc                current program counter
//   data_en/wr/addr   CPU data access tap
//   dma_en/addr       DMA access tap
//   irq               interrupt taken
//   region_en         per-region monitor enable
//   region_min/max    packed inclusive region bounds, region i at [16i+15:16i]
//   owner_min/max     packed inclusive owner-code bounds
//   reset             registered reset request to the core
//   viol_id           index of the last violating region
//   viol_cause        cause of the last violation
//   viol_count        saturating violation count
module hwmod_multi #(
  parameter int          NUM_REGIONS   = 4,
  parameter int          ID_W          = 4,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] RESET_HOLD    = 16'h0004,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic                      clk,
  input  logic                      puc,
  input  logic [15:0]               pc,
  input  logic                      data_en,
  input  logic                      data_wr,
  input  logic [15:0]               data_addr,
  input  logic                      dma_en,
  input  logic [15:0]               dma_addr,
  input  logic                      irq,
  input  logic [NUM_REGIONS-1:0]    region_en,
  input  logic [16*NUM_REGIONS-1:0] region_min,
  input  logic [16*NUM_REGIONS-1:0] region_max,
  input  logic [16*NUM_REGIONS-1:0] owner_min,
  input  logic [16*NUM_REGIONS-1:0] owner_max,
  output logic                      reset,
  output logic [ID_W-1:0]           viol_id,
  output logic [2:0]                viol_cause,
  output logic [CNT_W-1:0]          viol_count
);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic              reset_q, reset_d;
  logic [ID_W-1:0]   viol_id_q, viol_id_d;
  logic [2:0]        viol_cause_q, viol_cause_d;
  logic [CNT_W-1:0]  viol_count_q, viol_count_d;
  logic [15:0]       hold_q, hold_d;

  logic              viol_any;
  logic [ID_W-1:0]   viol_idx;
  logic [2:0]        viol_code;

  // Inclusive unsigned range test; lo > hi naturally yields an empty range.
  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (lo <= addr) && (addr <= hi);
  endfunction

  // Lowest cause code wins when several fire for one region.
  function automatic logic [2:0] region_cause(input logic c_foreign,
                                              input logic c_self_wr,
                                              input logic c_irq,
                                              input logic c_dma);
    if (c_foreign) return 3'b001;
    if (c_self_wr) return 3'b010;
    if (c_irq)     return 3'b011;
    if (c_dma)     return 3'b100;
    return 3'b000;
  endfunction

`ifndef HWMOD_MULTI_DMA_CHECK_EN
  logic unused_dma;
  assign unused_dma = ^{dma_en, dma_addr};
`endif

  // Per-region evaluation. Iterating from the top index down lets the
  // lowest violating index overwrite the others.
  always_comb begin
    viol_any  = 1'b0;
    viol_idx  = '0;
    viol_code = 3'b000;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      logic       d_hit, own, d_self, dma_hit;
      logic [2:0] code;
      d_hit  = region_en[i] &&
               in_range(data_addr, region_min[16*i +: 16], region_max[16*i +: 16]);
      own    = in_range(pc, owner_min[16*i +: 16], owner_max[16*i +: 16]);
      d_self = in_range(data_addr, owner_min[16*i +: 16], owner_max[16*i +: 16]);
`ifdef HWMOD_MULTI_DMA_CHECK_EN
      dma_hit = dma_en && region_en[i] &&
                in_range(dma_addr, region_min[16*i +: 16], region_max[16*i +: 16]);
`else
      dma_hit = 1'b0;
`endif
      code = region_cause(data_en && d_hit && !own,
                          data_en && data_wr && d_hit && own && d_self,
                          irq && own && region_en[i],
                          dma_hit);
      if (code != 3'b000) begin
        viol_any  = 1'b1;
        viol_idx  = ID_W'(i);
        viol_code = code;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    reset_d      = reset_q;
    viol_id_d    = viol_id_q;
    viol_cause_d = viol_cause_q;
    viol_count_d = viol_count_q;
    hold_d       = hold_q;
    case (state_q)
      ST_RUN: begin
        if (viol_any) begin
          state_d      = ST_HOLD;
          reset_d      = 1'b1;
          viol_id_d    = viol_idx;
          viol_cause_d = viol_code;
          if (viol_count_q != '1) viol_count_d = viol_count_q + CNT_W'(1);
          hold_d       = RESET_HOLD - 16'd1;
        end
      end
      ST_HOLD: begin
        if (hold_q == 16'd0) state_d = ST_WAIT;
        else                 hold_d  = hold_q - 16'd1;
      end
      ST_WAIT: begin
        // Violations seen here, including in the release cycle, are dropped.
        if (pc == RESET_HANDLER) begin
          reset_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        reset_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (puc) begin
      state_q      <= ST_RUN;
      reset_q      <= 1'b0;
      viol_id_q    <= '0;
      viol_cause_q <= 3'b000;
      viol_count_q <= '0;
      hold_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      reset_q      <= reset_d;
      viol_id_q    <= viol_id_d;
      viol_cause_q <= viol_cause_d;
      viol_count_q <= viol_count_d;
      hold_q       <= hold_d;
    end
  end

  assign reset      = reset_q;
  assign viol_id    = viol_id_q;
  assign viol_cause = viol_cause_q;
  assign viol_count = viol_count_q;

endmodule

// File: tb/tb_hwmod_multi.sv
// Testbench for hwmod_multi: drives access patterns cycle by cycle, pushes
// the expected registered outputs to a scoreboard queue and compares them
// after the following clock edge.
module tb_hwmod_multi;

  localparam int          NR   = 4;
  localparam int          IDW  = 4;
  localparam int          CW   = 8;
  localparam logic [15:0] HOLD = 16'h0004;

  logic              clk;
  logic              puc;
  logic [15:0]       pc;
  logic              data_en, data_wr;
  logic [15:0]       data_addr;
  logic              dma_en;
  logic [15:0]       dma_addr;
  logic              irq;
  logic [NR-1:0]     region_en;
  logic [16*NR-1:0]  region_min, region_max, owner_min, owner_max;
  logic              reset;
  logic [IDW-1:0]    viol_id;
  logic [2:0]        viol_cause;
  logic [CW-1:0]     viol_count;

  hwmod_multi #(
    .NUM_REGIONS(NR), .ID_W(IDW), .CNT_W(CW),
    .RESET_HOLD(HOLD), .RESET_HANDLER(16'h0000)
  ) dut (
    .clk(clk), .puc(puc), .pc(pc),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
    .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
    .region_en(region_en),
    .region_min(region_min), .region_max(region_max),
    .owner_min(owner_min), .owner_max(owner_max),
    .reset(reset), .viol_id(viol_id), .viol_cause(viol_cause),
    .viol_count(viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic           rst;
    logic [IDW-1:0] id;
    logic [2:0]     cause;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  // Expected diagnostic log, updated by the stimulus as violations are made.
  logic [IDW-1:0] e_id;
  logic [2:0]     e_cause;
  logic [CW-1:0]  e_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: expectation queued now, compared after the edge.
  task automatic step(input string tag, input logic e_rst);
    exp_t  e;
    string t;
    e.rst = e_rst; e.id = e_id; e.cause = e_cause; e.cnt = e_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".reset"}, 32'(reset),      32'(e.rst));
    check_val({t, ".id"},    32'(viol_id),    32'(e.id));
    check_val({t, ".cause"}, 32'(viol_cause), 32'(e.cause));
    check_val({t, ".count"}, 32'(viol_count), 32'(e.cnt));
  endtask

  task automatic idle();
    data_en = 1'b0; data_wr = 1'b0; irq = 1'b0; dma_en = 1'b0;
  endtask

  task automatic set_region(input int i, input logic [15:0] rmin,
                            input logic [15:0] rmax, input logic [15:0] omin,
                            input logic [15:0] omax);
    region_min[16*i +: 16] = rmin;
    region_max[16*i +: 16] = rmax;
    owner_min[16*i +: 16]  = omin;
    owner_max[16*i +: 16]  = omax;
  endtask

  // Reset must stay high through hold and while pc is away from the
  // handler, then drop right after pc reaches the handler.
  task automatic release_wait(input string tag);
    idle();
    pc = 16'hE000;
    for (int k = 0; k < int'(HOLD) + 4; k++) step({tag, ".held"}, 1'b1);
    pc = 16'h0000;
    step({tag, ".rel"}, 1'b0);
    pc = 16'hE000;
  endtask

  initial begin
    puc = 1'b1; pc = 16'hE000; idle();
    data_addr = 16'h0; dma_addr = 16'h0; region_en = '0;
    region_min = '0; region_max = '0; owner_min = '0; owner_max = '0;
    set_region(0, 16'h0400, 16'h0FFF, 16'hA000, 16'hDFFF);
    set_region(1, 16'h2000, 16'h2FFF, 16'h3000, 16'h3FFF);
    set_region(2, 16'h4000, 16'h4FFF, 16'hA200, 16'hA2FF);
    set_region(3, 16'h2000, 16'h2FFF, 16'h5000, 16'h5FFF);
    e_id = '0; e_cause = 3'b000; e_cnt = '0;

    step("puc_init", 1'b0);
    puc = 1'b0;

    // Region bounds: owner read at top, one past top, one below bottom.
    region_en = 4'b0001;
    pc = 16'hA100; data_en = 1'b1; data_addr = 16'h0FFF;
    step("own_rd_top", 1'b0);
    data_addr = 16'h1000;
    step("past_top", 1'b0);
    pc = 16'hE000;
    step("past_top_foreign", 1'b0);
    data_addr = 16'h03FF;
    step("below_bot", 1'b0);
    data_addr = 16'h0400;
    e_id = 4'd0; e_cause = 3'b001; e_cnt = 8'd1;
    step("viol_rd", 1'b1);
    release_wait("rel0");

    // Regions 1 and 3 overlap; lowest index wins. Violations while reset
    // is active (including the release cycle) are ignored.
    region_en = 4'b1010; pc = 16'hE000; data_en = 1'b1; data_addr = 16'h2800;
    e_id = 4'd1; e_cause = 3'b001; e_cnt = 8'd2;
    step("prio", 1'b1);
    for (int k = 0; k < int'(HOLD) + 3; k++) step("viol_in_wait", 1'b1);
    pc = 16'h0000;
    step("viol_at_rel", 1'b0);
    idle(); pc = 16'hE000;
    step("run_idle", 1'b0);

    // Self-modifying write beats a simultaneous irq from the same owner.
    set_region(1, 16'h3000, 16'h30FF, 16'h3000, 16'h3FFF);
    region_en = 4'b0010; pc = 16'h3010;
    data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h3080;
    step("self_rd", 1'b0);
    data_wr = 1'b1; irq = 1'b1;
    e_id = 4'd1; e_cause = 3'b010; e_cnt = 8'd3;
    step("self_wr", 1'b1);
    release_wait("rel_self");
    set_region(1, 16'h2000, 16'h2FFF, 16'h3000, 16'h3FFF);

    // Interrupt taken inside owner 2's code.
    region_en = 4'b0100; pc = 16'hA200; irq = 1'b1;
    e_id = 4'd2; e_cause = 3'b011; e_cnt = 8'd4;
    step("irq", 1'b1);
    release_wait("rel_irq");

    // DMA into region 0.
    region_en = 4'b0001; pc = 16'hE000; dma_en = 1'b1; dma_addr = 16'h0500;
`ifdef HWMOD_MULTI_DMA_CHECK_EN
    e_id = 4'd0; e_cause = 3'b100; e_cnt = e_cnt + 8'd1;
    step("dma", 1'b1);
    release_wait("rel_dma");
`else
    step("dma_off", 1'b0);
    step("dma_off2", 1'b0);
    idle();
`endif

    // Counter saturation.
    for (int n = 0; n < 256; n++) begin
      region_en = 4'b0001; pc = 16'hE000; data_en = 1'b1; data_addr = 16'h0400;
      e_id = 4'd0; e_cause = 3'b001;
      e_cnt = (e_cnt == 8'hFF) ? 8'hFF : e_cnt + 8'd1;
      step("sat", 1'b1);
      release_wait("sat_rel");
    end
    check_val("sat_final", 32'(viol_count), 32'hFF);

    // puc in the middle of hold clears everything and returns to RUN.
    data_en = 1'b1; data_addr = 16'h0400; pc = 16'hE000;
    step("pre_puc", 1'b1);
    idle();
    step("hold_puc", 1'b1);
    puc = 1'b1; data_en = 1'b1;
    e_id = '0; e_cause = 3'b000; e_cnt = '0;
    step("puc_hold", 1'b0);
    puc = 1'b0; idle();
    step("after_puc", 1'b0);
    data_en = 1'b1; data_addr = 16'h0400;
    e_id = 4'd0; e_cause = 3'b001; e_cnt = 8'd1;
    step("run_after_puc", 1'b1);
    release_wait("rel_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
